sparc_ram_responder: RTL and testbench

//  Memory-side responder for the datapath/control-unit RAM handshake (RAM_enable/RAM_OpCode in, MFC out).

---
 rtl/sparc_ram_responder.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_sparc_ram_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sparc_ram_responder.sv
// sparc_ram_responder
//   Memory-side responder for the control unit's RAM handshake. It accepts one
//   load or store request and waits LATENCY cycles. It then performs a
//   big-endian, byte-addressed access into local storage and raises MFC. MFC
//   stays high until the requester drops RAM_enable.
//
//   Build option: define RAM_ALIGN_CHECK_EN to abort misaligned halfword/word
//   accesses and flag them on Misaligned. Without it, the low address bits are
//   forced to alignment and Misaligned is tied low.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for RAM_enable; the request is captured on the edge it is seen
//   BUSY  | latency down-counter running; the access commits at terminal count
//   DONE  | MFC high, DataOut held; leaves on the first edge with RAM_enable low

module sparc_ram_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              RESET_n,
    input  logic              RAM_enable,
    input  logic [5:0]        RAM_OpCode,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              Misaligned
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;

    // Preload value for the latency counter. With LATENCY=1 the count starts
    // at zero, so the access commits on the first edge after capture.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              capture;
    logic              access;

    // Request fields captured at the IDLE->BUSY edge. Later input changes are ignored.
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [31:0]       dout_q;

    // Opcode decode
    logic              op_valid;
    logic              is_load;
    logic              is_store;
    logic              is_signed;
    acc_size_t         acc_size;
    logic              access_ok;

    // Byte-lane addressing and data
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] lane_addr [4];
    logic [7:0]        wr_byte   [4];
    logic [3:0]        wr_be;
    logic              wr_en;
    logic [31:0]       rd_word;
    logic [31:0]       load_result;

    logic [7:0]        mem [DEPTH];

`ifdef RAM_ALIGN_CHECK_EN
    logic              misal;
    logic              mis_q;
`endif

    // Decode the captured opcode into size, direction and extension
    always_comb begin
        op_valid  = 1'b1;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        acc_size  = SZ_WORD;
        unique case (op_q)
            OP_LD:   begin is_load  = 1'b1; acc_size = SZ_WORD; end
            OP_LDUB: begin is_load  = 1'b1; acc_size = SZ_BYTE; end
            OP_LDUH: begin is_load  = 1'b1; acc_size = SZ_HALF; end
            OP_ST:   begin is_store = 1'b1; acc_size = SZ_WORD; end
            OP_STB:  begin is_store = 1'b1; acc_size = SZ_BYTE; end
            OP_STH:  begin is_store = 1'b1; acc_size = SZ_HALF; end
            OP_LDSB: begin is_load  = 1'b1; acc_size = SZ_BYTE; is_signed = 1'b1; end
            OP_LDSH: begin is_load  = 1'b1; acc_size = SZ_HALF; is_signed = 1'b1; end
            default: op_valid = 1'b0;
        endcase
    end

`ifdef RAM_ALIGN_CHECK_EN
    // A misaligned access is aborted, so the captured address is used unmodified
    always_comb begin
        misal = 1'b0;
        if (op_valid) begin
            if (acc_size == SZ_HALF) misal = addr_q[0];
            if (acc_size == SZ_WORD) misal = (addr_q[1:0] != 2'b00);
        end
        base_addr = addr_q;
        access_ok = op_valid && !misal;
    end
`else
    // Without the check, the low address bits are cleared to the access size
    always_comb begin
        base_addr = addr_q;
        if (acc_size == SZ_HALF) base_addr[0]   = 1'b0;
        if (acc_size == SZ_WORD) base_addr[1:0] = 2'b00;
        access_ok = op_valid;
    end
`endif

    // Lane i is the byte at base+i. Lanes past the top of storage wrap modulo the storage size.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = base_addr + ADDR_W'(i);
        end
    end

    // Big-endian read: lane 0 is the most significant byte
    always_comb begin
        rd_word = {mem[lane_addr[0]], mem[lane_addr[1]],
                   mem[lane_addr[2]], mem[lane_addr[3]]};
    end

    // Narrow the read word and extend it to 32 bits
    always_comb begin
        load_result = rd_word;
        unique case (acc_size)
            SZ_BYTE: load_result = is_signed ? {{24{rd_word[31]}}, rd_word[31:24]}
                                             : {24'h000000, rd_word[31:24]};
            SZ_HALF: load_result = is_signed ? {{16{rd_word[31]}}, rd_word[31:16]}
                                             : {16'h0000, rd_word[31:16]};
            default: load_result = rd_word;
        endcase
    end

    // Store data steering. The MSB of the stored quantity goes to the lowest address.
    always_comb begin
        wr_be = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            wr_byte[i] = 8'h00;
        end
        unique case (acc_size)
            SZ_BYTE: begin
                wr_be      = 4'b0001;
                wr_byte[0] = data_q[7:0];
            end
            SZ_HALF: begin
                wr_be      = 4'b0011;
                wr_byte[0] = data_q[15:8];
                wr_byte[1] = data_q[7:0];
            end
            default: begin
                wr_be      = 4'b1111;
                wr_byte[0] = data_q[31:24];
                wr_byte[1] = data_q[23:16];
                wr_byte[2] = data_q[15:8];
                wr_byte[3] = data_q[7:0];
            end
        endcase
    end

    // Next-state logic and the latency down-counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (RAM_enable) begin
                    capture = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!RAM_enable) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Write only at commit. A reset during BUSY forces IDLE, so the write never fires.
    assign wr_en = access && is_store && access_ok;

    // State register, counter and captured request
    always_ff @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 6'd0;
            addr_q  <= '0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                op_q   <= RAM_OpCode;
                addr_q <= Address;
                data_q <= DataIn;
            end
        end
    end

    // Load result register. Stores leave DataOut unchanged; rejected accesses clear it.
    always_ff @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            dout_q <= 32'd0;
        end else if (access) begin
            if (!access_ok) begin
                dout_q <= 32'd0;
            end else if (is_load) begin
                dout_q <= load_result;
            end
        end
    end

    // Byte storage: no reset, contents survive RESET_n
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[lane_addr[i]] <= wr_byte[i];
            end
        end
    end

`ifdef RAM_ALIGN_CHECK_EN
    // Misaligned is set with MFC and cleared on the edge that leaves DONE
    always_ff @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            mis_q <= 1'b0;
        end else if (access) begin
            mis_q <= misal;
        end else if (state_q == DONE && !RAM_enable) begin
            mis_q <= 1'b0;
        end
    end

    assign Misaligned = mis_q;
`else
    assign Misaligned = 1'b0;
`endif

    assign MFC     = (state_q == DONE);
    assign DataOut = dout_q;

endmodule

// File: tb/tb_sparc_ram_responder.sv
// Randomized bench for sparc_ram_responder. It compares against a reference
// model that works on byte arrays with plain arithmetic. Honours RAM_ALIGN_CHECK_EN.

module tb_sparc_ram_responder;

    localparam int LAT = 2;

    localparam logic [5:0] LD   = 6'd0;
    localparam logic [5:0] LDUB = 6'd1;
    localparam logic [5:0] LDUH = 6'd2;
    localparam logic [5:0] ST   = 6'd4;
    localparam logic [5:0] STB  = 6'd5;
    localparam logic [5:0] STH  = 6'd6;
    localparam logic [5:0] LDSB = 6'd9;
    localparam logic [5:0] LDSH = 6'd10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [5:0]  opc = 6'd0;
    logic [7:0]  addr = 8'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic        mfc;
    logic        mis;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  ref_mem [256];
    logic [31:0] exp_dout = 32'd0;
    logic        exp_mis = 1'b0;
    logic [5:0]  ops [8] = '{LD, LDUB, LDUH, ST, STB, STH, LDSB, LDSH};

    sparc_ram_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
        .Clk        (clk),
        .RESET_n    (rst_n),
        .RAM_enable (en),
        .RAM_OpCode (opc),
        .Address    (addr),
        .DataIn     (din),
        .DataOut    (dout),
        .MFC        (mfc),
        .Misaligned (mis)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: size/sign from the opcode, bytes combined most-significant first
    function automatic void model_apply(input logic [5:0] op, input logic [7:0] a,
                                        input logic [31:0] d);
        int     size;
        bit     sgn;
        bit     st;
        bit     ok;
        int     base;
        longint val;
        ok = 1; sgn = 0; st = 0; size = 4;
        case (op)
            LD:   size = 4;
            LDUB: size = 1;
            LDUH: size = 2;
            ST:   begin size = 4; st = 1; end
            STB:  begin size = 1; st = 1; end
            STH:  begin size = 2; st = 1; end
            LDSB: begin size = 1; sgn = 1; end
            LDSH: begin size = 2; sgn = 1; end
            default: ok = 0;
        endcase
        exp_mis = 1'b0;
        if (!ok) begin
            exp_dout = 32'd0;
            return;
        end
`ifdef RAM_ALIGN_CHECK_EN
        if (int'(a) % size != 0) begin
            exp_mis  = 1'b1;
            exp_dout = 32'd0;
            return;
        end
`endif
        base = int'(a) - (int'(a) % size);
        if (st) begin
            for (int j = 0; j < size; j++)
                ref_mem[(base + j) % 256] = 8'(d >> (8 * (size - 1 - j)));
        end else begin
            val = 0;
            for (int j = 0; j < size; j++)
                val = val * 256 + longint'(ref_mem[(base + j) % 256]);
            if (sgn && val >= (64'sd1 <<< (8 * size - 1)))
                val = val - (64'sd1 <<< (8 * size));
            exp_dout = val[31:0];
        end
    endfunction

    // One handshake. 'early' drops RAM_enable right after capture; 'hold' extra cycles in DONE.
    task automatic do_req(input logic [5:0] op, input logic [7:0] a, input logic [31:0] d,
                          input int hold, input bit early);
        logic [31:0] old_dout;
        @(negedge clk);
        en = 1'b1; opc = op; addr = a; din = d;
        @(posedge clk); #1;
        old_dout = exp_dout;
        model_apply(op, a, d);
        chk("mfc_at_capture", {31'd0, mfc}, 32'd0);
        opc  = 6'($urandom);
        addr = 8'($urandom);
        din  = $urandom;
        if (early) en = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clk); #1;
            chk("mfc_timing", {31'd0, mfc}, (i == LAT) ? 32'd1 : 32'd0);
            chk("dout", dout, (i == LAT) ? exp_dout : old_dout);
        end
        chk("misaligned", {31'd0, mis}, {31'd0, exp_mis});
        if (early) begin
            @(posedge clk); #1;
        end else begin
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                chk("mfc_hold", {31'd0, mfc}, 32'd1);
                chk("dout_hold", dout, exp_dout);
            end
            @(negedge clk);
            en = 1'b0;
            @(posedge clk); #1;
        end
        chk("mfc_drop", {31'd0, mfc}, 32'd0);
        chk("mis_clear", {31'd0, mis}, 32'd0);
        chk("dout_after", dout, exp_dout);
    endtask

    initial begin
        #12;
        chk("rst_mfc", {31'd0, mfc}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_mis", {31'd0, mis}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill storage so every byte is known to the model
        for (int i = 0; i < 64; i++) do_req(ST, 8'(i * 4), $urandom, 0, 0);

        do_req(ST, 8'h10, 32'hDEADBEEF, 0, 0);
        do_req(LD, 8'h10, 32'h0, 0, 0);
        chk("dir_ld", dout, 32'hDEADBEEF);
        do_req(LDUB, 8'h11, 32'h0, 0, 0);
        chk("dir_ldub", dout, 32'h000000AD);
        do_req(STH, 8'h20, 32'h12348001, 0, 0);
        do_req(LDSH, 8'h20, 32'h0, 0, 0);
        chk("dir_ldsh", dout, 32'hFFFF8001);
        do_req(LDUH, 8'h20, 32'h0, 0, 0);
        chk("dir_lduh", dout, 32'h00008001);
        do_req(STB, 8'h23, 32'hABCDEF80, 0, 0);
        do_req(LDSB, 8'h23, 32'h0, 0, 0);
        chk("dir_ldsb", dout, 32'hFFFFFF80);
        do_req(LD, 8'h10, 32'h0, 5, 0);
        do_req(ST, 8'h30, 32'hCAFEF00D, 0, 1);
        do_req(LD, 8'h30, 32'h0, 0, 0);
        chk("dir_early_st", dout, 32'hCAFEF00D);
        do_req(LD, 8'h12, 32'h0, 0, 0);
`ifdef RAM_ALIGN_CHECK_EN
        chk("dir_misal_ld", dout, 32'h0);
`else
        chk("dir_forced_align", dout, 32'hDEADBEEF);
`endif
        do_req(6'h3F, 8'h10, 32'h55555555, 0, 0);
        chk("dir_bad_op", dout, 32'h0);
        do_req(LD, 8'h10, 32'h0, 0, 0);
        chk("dir_bad_op_nowr", dout, 32'hDEADBEEF);
        do_req(ST, 8'hFE, 32'h11223344, 0, 0);
        do_req(LD, 8'hFC, 32'h0, 0, 0);
`ifndef RAM_ALIGN_CHECK_EN
        chk("dir_st_fe", dout, 32'h11223344);
`endif

        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            do_req(op, 8'($urandom), $urandom, $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of BUSY abandons a pending store
        @(negedge clk);
        en = 1'b1; opc = ST; addr = 8'h40; din = 32'h0BADF00D;
        @(posedge clk); #3;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("rst_busy_mfc", {31'd0, mfc}, 32'd0);
        chk("rst_busy_dout", dout, 32'd0);
        exp_dout = 32'd0;
        exp_mis  = 1'b0;
        @(posedge clk); #1;
        chk("rst_hold_mfc", {31'd0, mfc}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(LD, 8'h40, 32'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
